// File: rtl/alu_issue.sv
// Single-issue front end for an external combinational ALU: accepts one instruction,
// reads operands from a 16x32 register file, issues to the ALU and writes the result back.
module alu_issue #(
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] val1,
    output logic [31:0] val2,
    output logic [4:0]  aluop,
    output logic        is_alu_op,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [4:0] ALUOP_ADD  = 5'd0;
    localparam logic [4:0] ALUOP_SUB  = 5'd1;
    localparam logic [4:0] ALUOP_MUL  = 5'd2;
    localparam logic [4:0] ALUOP_DIV  = 5'd3;
    localparam logic [4:0] ALUOP_AND  = 5'd4;
    localparam logic [4:0] ALUOP_OR   = 5'd5;
    localparam logic [4:0] ALUOP_NOT  = 5'd6;
    localparam logic [4:0] ALUOP_XOR  = 5'd7;
    localparam logic [4:0] ALUOP_SHL  = 5'd8;
    localparam logic [4:0] ALUOP_SHR  = 5'd9;
    localparam logic [4:0] ALUOP_ASR  = 5'd10;
    localparam logic [4:0] ALUOP_MOV  = 5'd11;
    localparam logic [4:0] ALUOP_MOVL = 5'd12;
    localparam logic [4:0] ALUOP_MOVH = 5'd13;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WB
    } state_t;

    state_t      state;
    logic [31:0] regs [16];
    logic [3:0]  rd_q;

    logic [4:0]  in_op;
    logic        in_imm;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [15:0] in_imm16;
    logic        in_legal;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] op2_val;

    function automatic logic [31:0] read_reg(input logic [3:0] addr);
        return (ZERO_R0 && addr == 4'd0) ? 32'h0 : regs[addr];
    endfunction

    assign in_op    = instr[31:27];
    assign in_imm   = instr[26];
    assign in_rd    = instr[25:22];
    assign in_rs1   = instr[21:18];
    assign in_rs2   = instr[17:14];
    assign in_imm16 = instr[15:0];

    always_comb begin
        in_legal = 1'b0;
        case (in_op)
            ALUOP_ADD, ALUOP_SUB, ALUOP_MUL, ALUOP_DIV, ALUOP_AND, ALUOP_OR, ALUOP_NOT,
            ALUOP_XOR, ALUOP_SHL, ALUOP_SHR, ALUOP_ASR, ALUOP_MOV, ALUOP_MOVL,
            ALUOP_MOVH: in_legal = 1'b1;
            default:    in_legal = 1'b0;
        endcase
    end

    // Operands are read from the incoming word on the accept edge; the previous
    // write-back has already landed because accept is only possible from IDLE.
    always_comb begin
        rs1_val = read_reg(in_rs1);
        rs2_val = read_reg(in_rs2);
        if (!in_imm)
            op2_val = rs2_val;
        else if (in_op == ALUOP_MOVH)
            op2_val = {in_imm16, 16'h0};
        else
            op2_val = {16'h0, in_imm16};
    end

    assign instr_ready = (state == IDLE) && rst_n;
    assign dbg_data    = read_reg(dbg_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            // NOTE: the register file is cleared by reset, so it stays in flops
            // rather than mapping to a RAM macro without a reset port.
            for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
            rd_q      <= 4'h0;
            val1      <= 32'h0;
            val2      <= 32'h0;
            aluop     <= 5'h0;
            is_alu_op <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= 4'h0;
            wb_data   <= 32'h0;
            illegal   <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        rd_q <= in_rd;
                        if (in_legal) begin
                            state     <= ISSUE;
                            is_alu_op <= 1'b1;
                            aluop     <= in_op;
                            val1      <= rs1_val;
                            val2      <= op2_val;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state     <= WB;
                    is_alu_op <= 1'b0;
                    aluop     <= 5'h0;
                    val1      <= 32'h0;
                    val2      <= 32'h0;
                    wb_valid  <= 1'b1;
                    wb_rd     <= rd_q;
                    wb_data   <= alu_result;
                end
                WB: begin
                    state    <= IDLE;
                    wb_valid <= 1'b0;
                    if (!(ZERO_R0 && wb_rd == 4'd0)) regs[wb_rd] <= wb_data;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter ZERO_R0, default 1: when 1, r0 reads as 0 and writes to r0 are discarded; when 0, r0 is an ordinary register.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 instr_valid  in  1  instruction word offered.
REQ-005 instr_ready  out  1  block can accept an instruction this cycle.
REQ-006 instr  in  32  instruction word: [31:27] aluop, [26] I, [25:22] rd, [21:18] rs1, [17:14] rs2 (I=0), [15:0] imm16 (I=1).
REQ-007 val1  out  32  operand 1 to the ALU.
REQ-008 val2  out  32  operand 2 to the ALU.
REQ-009 aluop  out  5  ALU operation, using the ALUOP_* codes from defines.v.
REQ-010 is_alu_op  out  1  ALU enable, high for exactly the issue cycle.
REQ-011 alu_result  in  32  combinational ALU result for the current val1/val2/aluop.
REQ-012 wb_valid  out  1  one-cycle pulse marking a completed register write.
REQ-013 wb_rd  out  4  register written; valid with wb_valid.
REQ-014 wb_data  out  32  value written; valid with wb_valid.
REQ-015 illegal  out  1  one-cycle pulse on a rejected opcode.
REQ-016 dbg_addr  in  4  debug read address.
REQ-017 dbg_data  out  32  combinational read of register dbg_addr, with r0 read as 0 when ZERO_R0=1.

Function
REQ-018 Internal register file: 16 x 32-bit registers, 2 read ports and 1 write port.
REQ-019 FSM states: IDLE, ISSUE, WB; instr_ready=1 only in IDLE.
REQ-020 The handshake completes on the edge where instr_valid and instr_ready are both high; the block then latches instr and moves IDLE->ISSUE.
REQ-021 Legal opcodes are ADD, SUB, MUL, DIV, AND, OR, NOT, XOR, SHL, SHR, ASR, MOV, MOVL and MOVH.
REQ-022 An opcode not listed in REQ-021: no issue and no write; illegal=1 in the cycle after acceptance; FSM returns IDLE->IDLE, so instr_ready stays 1.
REQ-023 In ISSUE:
- is_alu_op=1 and aluop=latched op.
- val1=reg[rs1].
- val2 depends on I and op:
  - I=0: val2=reg[rs2].
  - I=1, op MOVH: val2={imm16,16'h0}.
  - I=1, any other op: val2={16'h0,imm16}.
REQ-024 ISSUE->WB unconditionally after one cycle; alu_result is captured into a result register on the ISSUE->WB edge.
REQ-025 In WB:
- wb_valid=1, wb_rd=rd, wb_data=captured result.
- The register file write to rd takes effect on the WB->IDLE edge.
- The write is suppressed when rd=0 and ZERO_R0=1, but wb_valid still pulses.
REQ-026 Latency: accept at edge N; ISSUE during cycle N+1; WB during cycle N+2; the written value is readable from cycle N+3.
REQ-027 Throughput: one instruction per 3 cycles; an instruction held valid while instr_ready=0 is accepted on the first edge after the FSM returns to IDLE.
REQ-028 Outside ISSUE: is_alu_op=0, val1=0, val2=0, aluop=0.
REQ-029 Outside WB: wb_valid=0; wb_rd and wb_data hold their last values.
REQ-030 Back-to-back dependency: an instruction that reads the rd of the previous instruction reads the newly written value; no forwarding is needed, given REQ-026.
REQ-031 instr changes while instr_ready=0 are ignored; the latched copy alone drives ISSUE and WB.
REQ-032 DIV by zero is forwarded unchanged; the block writes whatever alu_result is; no flag.

Reset
REQ-033 When rst_n=0 at a rising edge:
- FSM goes to IDLE.
- All 16 registers are cleared to 0.
- The latched instruction and result register are cleared.
- wb_valid=0, wb_rd=0, wb_data=0, illegal=0, is_alu_op=0.
REQ-034 Reset asserted in ISSUE or WB aborts the instruction: no register write and no wb_valid pulse.
REQ-035 instr_ready=0 during reset; it is 1 in the first cycle after rst_n returns high.

Verification
REQ-036 After reset: MOVL r1,#5; MOVL r2,#7; ADD r3,r1,r2 -> wb_data=12, wb_rd=3; dbg_addr=3 reads 12.
REQ-037 MOVH r4,#0xABCD -> val2=0xABCD0000 during ISSUE; r4=0xABCD0000.
REQ-038 ZERO_R0=1, MOVL r0,#9 -> wb_valid pulses, wb_rd=0; dbg_addr=0 reads 0.
REQ-039 Undefined opcode with instr_valid=1 -> illegal=1 for one cycle, is_alu_op stays 0, no wb_valid, instr_ready=1 the next cycle.
REQ-040 Three instructions presented with instr_valid held high continuously -> accepted at edges N, N+3 and N+6; exactly 3 wb_valid pulses.
REQ-041 rst_n dropped during ISSUE of ADD r5 -> no wb_valid; r5=0 after reset.
